uart_packetizer_framed: RTL and testbench
=========================================

Name: uart_packetizer_framed

Overview:
Parametrised successor to the single-byte UART packetizer. It buffers incoming bytes in an internal FIFO and groups them into framed packets: SOF byte, LEN byte, 1..MAX_LEN payload bytes, then an XOR checksum byte. The packet is serialised on one UART TX line with a configurable bit period. It sits between a byte-stream producer and the board UART pin, and replaces the FIFO + FSM + uart_tx trio with a single flow-controlled block.

Parameters:
DEPTH, 16, FIFO entries; power of 2, 4..256
MAX_LEN, 8, max payload bytes per packet; 1..min(DEPTH,255)
CLKS_PER_BIT, 868, clk cycles per UART bit; >=2
SOF_BYTE, 8'hA5, start-of-frame marker byte

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
data_in  in  8  payload byte
data_valid  in  1  data_in valid
data_ready  out  1  FIFO can accept; write occurs when data_valid && data_ready
flush  in  1  one-cycle pulse: send buffered bytes now, even if fewer than MAX_LEN
serial_out  out  1  UART TX line, idle high
tx_busy  out  1  a packet is being transmitted
pkt_done  out  1  one-cycle pulse after the last stop bit of a packet
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO emptied; fifo_level=0; data_ready=1; serial_out=1; tx_busy=0; pkt_done=0; flush latch cleared; FSM=IDLE. Reset mid-packet aborts the frame, and the line goes high immediately.
- FIFO: write-only from the input port and read-only by the FSM. data_ready = (fifo_level != DEPTH); writes while full are impossible. A simultaneous read and write leaves the level unchanged. Pointers wrap modulo DEPTH.
- flush_pend latch: set by flush. Cleared when a packet starts. Also cleared if flush arrives while FIFO empty and FSM IDLE (no empty packets, ever).
- FSM states: IDLE -> SOF -> LEN -> PAY -> CSUM -> DONE -> IDLE.
- IDLE: start when fifo_level >= MAX_LEN, or when flush_pend && fifo_level > 0. On start, capture len = min(fifo_level, MAX_LEN) and clear csum. tx_busy rises the cycle after the start condition is seen.
- SOF: transmit SOF_BYTE.
- LEN: transmit len; csum ^= len.
- PAY: pop one FIFO byte per byte slot; transmit it; csum ^= byte. Repeat len times. Bytes written during the packet are not added to it.
- CSUM: transmit csum (XOR of LEN and all payload bytes).
- DONE: pkt_done=1 for exactly one cycle; tx_busy drops in the same cycle; return to IDLE. If the start condition holds again, the next packet starts the following cycle.
- UART byte frame: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each exactly CLKS_PER_BIT cycles.
  - Bytes within a packet are back-to-back: the next start bit directly follows the previous stop bit.
  - The first start bit begins 1 cycle after the FSM leaves IDLE.
  - Packet duration = (len+3)*10*CLKS_PER_BIT cycles.
- Bit timer: counter 0..CLKS_PER_BIT-1. Bit index 0..9. No fractional baud.
- flush arriving during transmission sets flush_pend; it is serviced in the next IDLE.

Optional Feature:
UART_PARITY_EN: when defined, each UART frame carries an even-parity bit between data bit 7 and the stop bit. Frame becomes 11 bits; packet duration = (len+3)*11*CLKS_PER_BIT cycles. Parity is computed over the 8 data bits of each byte, including SOF, LEN and CSUM. When undefined, frames are 8N1 as above and no parity logic is present.

Test Plan:
- Reset: hold rst=0 mid-packet -> serial_out=1, tx_busy=0, fifo_level=0, data_ready=1 within the same cycle. After release, no residual bits are sent.
- Full packet (MAX_LEN=4, CLKS_PER_BIT=4): write 11,22,33,44 -> line carries A5,04,11,22,33,44, then checksum 04^11^22^33^44 = 0x40, LSB first. pkt_done pulses at cycle 7*40 after the first start bit; fifo_level=0.
- Flush short packet: write 0x7E, pulse flush -> A5,01,7E,7F sent. A flush pulse with an empty FIFO -> no traffic, tx_busy stays 0.
- Backpressure (DEPTH=4, MAX_LEN=4, hold data_valid=1): data_ready=0 at fifo_level=4; no byte is lost or duplicated. After the FSM pops, data_ready=1 and the next bytes form the second packet, which starts 1 cycle after the first pkt_done.
- Simultaneous events: write during the PAY pop at fifo_level=DEPTH-1 -> level stays constant. A flush during transmission is serviced right after pkt_done.
- With UART_PARITY_EN (CLKS_PER_BIT=4): payload 0x07 -> parity bit 1 in that frame; LEN=0x01 -> parity 1; frame length is 44 cycles.

Source files
------------

// File: rtl/uart_packetizer_framed.sv
// uart_packetizer_framed: byte FIFO feeding a framed-packet UART transmitter.
// Packet on the wire: SOF_BYTE, LEN, LEN payload bytes, XOR(LEN, payload).
// Each byte is sent as 8N1, LSB first. Define UART_PARITY_EN to add an
// even-parity bit after data bit 7 (8E1 frames).
module uart_packetizer_framed #(
    parameter int         DEPTH        = 16,
    parameter int         MAX_LEN      = 8,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SOF_BYTE     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic                   flush,
    output logic                   serial_out,
    output logic                   tx_busy,
    output logic                   pkt_done,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // shift register holds everything after the start bit
    localparam int SW = NBITS - 1;

    typedef enum logic [2:0] {IDLE, SOF, LEN, PAY, CSUM, DONE} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          wr_en, pop;
    logic [7:0]    head;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d, rem_q, rem_d, csum_q, csum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          active_q, active_d, serial_q, serial_d;
    logic          busy_q, busy_d, done_q, done_d, pend_q, pend_d;
    logic          start, frame_end, load;
    logic [7:0]    load_byte;

    assign data_ready = (lvl_q != LW'(DEPTH));
    assign wr_en      = data_valid && data_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_level = lvl_q;
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign pkt_done   = done_q;

    // FIFO storage: written from the input port only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

    // FIFO pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        lvl_d    = lvl_q + LW'(wr_en) - LW'(pop);
    end

    // Bit timer, flush latch and packet sequencing
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        active_d  = active_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pend_d    = pend_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;
        start     = (state_q == IDLE) &&
                    ((lvl_q >= LW'(MAX_LEN)) || (pend_q && lvl_q != '0));
        frame_end = active_q && (cnt_q == CW'(CLKS_PER_BIT - 1)) &&
                    (bit_q == 4'(NBITS - 1));

        // advance the current frame; the line returns high after the stop bit
        if (active_q) begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d = '0;
                if (bit_q == 4'(NBITS - 1)) begin
                    active_d = 1'b0;
                    serial_d = 1'b1;
                end else begin
                    bit_d    = bit_q + 4'd1;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // an idle flush with nothing buffered is dropped so no empty packet follows
        if (flush) pend_d = !(state_q == IDLE && lvl_q == '0);
        if (start) pend_d = 1'b0;

        // a new frame is loaded on the stop bit's last cycle so bytes run back-to-back
        case (state_q)
            IDLE: if (start) begin
                state_d = SOF;
                len_d   = (lvl_q >= LW'(MAX_LEN)) ? 8'(MAX_LEN) : 8'(lvl_q);
                csum_d  = 8'h00;
                busy_d  = 1'b1;
            end
            SOF: if (!active_q) begin
                load      = 1'b1;
                load_byte = SOF_BYTE;
            end else if (frame_end) begin
                load      = 1'b1;
                load_byte = len_q;
                csum_d    = csum_q ^ len_q;
                state_d   = LEN;
            end
            LEN: if (frame_end) begin
                load      = 1'b1;
                load_byte = head;
                pop       = 1'b1;
                csum_d    = csum_q ^ head;
                rem_d     = len_q - 8'd1;
                state_d   = PAY;
            end
            PAY: if (frame_end) begin
                load = 1'b1;
                if (rem_q != 8'd0) begin
                    load_byte = head;
                    pop       = 1'b1;
                    csum_d    = csum_q ^ head;
                    rem_d     = rem_q - 8'd1;
                end else begin
                    load_byte = csum_q;
                    state_d   = CSUM;
                end
            end
            CSUM: if (frame_end) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // frame = start bit on the line now, rest queued LSB first
        if (load) begin
`ifdef UART_PARITY_EN
            shift_d = {1'b1, ^load_byte, load_byte};
`else
            shift_d = {1'b1, load_byte};
`endif
            serial_d = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            active_d = 1'b1;
        end
    end

    // State registers; reset aborts any frame and forces the line high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            state_q  <= IDLE;
            len_q    <= 8'h00;
            rem_q    <= 8'h00;
            csum_q   <= 8'h00;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            active_q <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
        end
    end
endmodule

// File: tb/tb_uart_packetizer_framed.sv
// Bench for uart_packetizer_framed: queue-based packet model checked every
// cycle, plus directed packets decoded straight off the serial line.
`timescale 1ns/1ps
module tb_uart_packetizer_framed;
    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 4;
    localparam int CPB     = 4;
    localparam logic [7:0] SOF = 8'hA5;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int F = FB * CPB;

    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0, flush = 1'b0;
    logic       data_ready, serial_out, tx_busy, pkt_done;
    logic [2:0] fifo_level;
    int         checks = 0, errors = 0;
    int         tcyc = 0;

    uart_packetizer_framed #(
        .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .CLKS_PER_BIT(CPB), .SOF_BYTE(SOF)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .flush(flush), .serial_out(serial_out),
        .tx_busy(tx_busy), .pkt_done(pkt_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); tcyc++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mq: bytes buffered; wave: expected {line,busy,done} per upcoming cycle;
    // pops: cycles at which a payload byte leaves the FIFO.
    logic [7:0] mq[$];
    logic [2:0] wave[$];
    int         pops[$];
    bit         fpend;
    int         cyc;
    logic       m_line = 1'b1, m_busy = 1'b0, m_done = 1'b0;

    initial forever begin : model
        int lvl, len;
        bit idle, start, wr;
        logic [7:0] bq[$];
        logic [7:0] cs;
        logic [FB-1:0] fr;
        logic [2:0] w;
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete(); wave.delete(); pops.delete();
            fpend = 0; cyc = 0;
            m_line = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            cyc++;
            lvl   = mq.size();
            idle  = (wave.size() == 0);
            start = idle && (lvl >= MAX_LEN || (fpend && lvl > 0));
            wr    = data_valid && (lvl != DEPTH);
            if (pops.size() > 0 && pops[0] == cyc) begin
                void'(pops.pop_front());
                void'(mq.pop_front());
            end
            if (wr) mq.push_back(data_in);
            if (flush) fpend = !(idle && lvl == 0);
            if (start) begin
                fpend = 0;
                len = (lvl < MAX_LEN) ? lvl : MAX_LEN;
                bq.delete();
                bq.push_back(SOF);
                bq.push_back(8'(len));
                cs = 8'(len);
                for (int i = 0; i < len; i++) begin
                    bq.push_back(mq[i]);
                    cs ^= mq[i];
                    pops.push_back(cyc + 1 + (2 + i) * F);
                end
                bq.push_back(cs);
                wave.push_back(3'b110);
                foreach (bq[j]) begin
`ifdef UART_PARITY_EN
                    fr = {1'b1, ^bq[j], bq[j], 1'b0};
`else
                    fr = {1'b1, bq[j], 1'b0};
`endif
                    for (int b = 0; b < FB; b++)
                        for (int c = 0; c < CPB; c++) wave.push_back({fr[b], 2'b10});
                end
                wave.push_back(3'b101);
                wave.push_back(3'b100);
            end
            if (wave.size() > 0) w = wave.pop_front();
            else w = 3'b100;
            {m_line, m_busy, m_done} = w;
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("serial_out", serial_out, m_line);
            chk("tx_busy", tx_busy, m_busy);
            chk("pkt_done", pkt_done, m_done);
            chk("fifo_level", fifo_level, mq.size());
            chk("data_ready", data_ready, mq.size() != DEPTH);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic wr_byte(input logic [7:0] b);
        data_in = b; data_valid = 1'b1;
        @(negedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output logic p, output int t0);
        int t;
        b = 8'h00; p = 1'b0; t0 = 0; t = 0;
        while (serial_out !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
        if (t >= 4000) begin chk("rx_timeout", 1, 0); return; end
        t0 = tcyc;
        repeat (CPB / 2) @(negedge clk);
        chk("rx_start_bit", serial_out, 0);
        for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = serial_out; end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = serial_out;
        chk("rx_parity", p, ^b);
`endif
        repeat (CPB) @(negedge clk);
        chk("rx_stop_bit", serial_out, 1);
    endtask

    task automatic wait_done(output int td);
        int t = 0;
        while (pkt_done !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
        if (t >= 4000) chk("done_timeout", 1, 0);
        td = tcyc;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [7:0] b, acc_b;
        logic p, acc;
        int t0, tx, td, t, last_done, pairs, dens;
        bit seen, pb, saw_full;
        logic [7:0] exp1 [7];
        logic [7:0] exp2 [4];
        exp1 = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
        exp2 = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        acc_b = 8'h00;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", serial_out, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", data_ready, 1);
        #1 rst = 1'b1;
        @(negedge clk); #1;

        // full packet
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
        t0 = 0;
        for (int i = 0; i < 7; i++) begin
            rx_byte(b, p, tx);
            if (i == 0) t0 = tx;
            chk("pkt1_byte", b, exp1[i]);
        end
        wait_done(td);
        chk("pkt1_done_time", td - t0, 7 * F);
        chk("pkt1_level", fifo_level, 0);
        @(negedge clk); #1;

        // flush short packet
        wr_byte(8'h7E);
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            rx_byte(b, p, tx);
            if (i == 0) t0 = tx;
            chk("flush_byte", b, exp2[i]);
        end
        wait_done(td);
        chk("flush_done_time", td - t0, 4 * F);
        @(negedge clk); #1;

`ifdef UART_PARITY_EN
        // parity: LEN 0x01 and payload 0x07 both carry parity 1; 4 frames of 44 cycles
        wr_byte(8'h07);
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            rx_byte(b, p, tx);
            if (i == 0) t0 = tx;
            if (i == 1) begin chk("par_len_byte", b, 8'h01); chk("par_len_bit", p, 1); end
            if (i == 2) begin chk("par_pay_byte", b, 8'h07); chk("par_pay_bit", p, 1); end
            if (i == 3) chk("par_csum_byte", b, 8'h06);
        end
        wait_done(td);
        chk("par_done_time", td - t0, 176);
        @(negedge clk); #1;
`endif

        // flush with an empty FIFO: no traffic, and the flush is not remembered
        repeat (5) @(negedge clk); #1;
        pulse_flush();
        seen = 0;
        repeat (100) begin @(negedge clk); if (tx_busy || !serial_out) seen = 1; end
        chk("empty_flush_quiet", seen, 0);
        #1 wr_byte(8'h5A);
        seen = 0;
        repeat (100) begin @(negedge clk); if (tx_busy) seen = 1; end
        chk("no_stale_flush", seen, 0);

        // reset mid-packet
        #1 wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        t = 0;
        while (!tx_busy && t < 100) begin @(negedge clk); t++; end
        chk("rstmid_started", tx_busy, 1);
        repeat (50) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rstmid_serial", serial_out, 1);
        chk("rstmid_busy", tx_busy, 0);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_ready", data_ready, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (400) begin @(negedge clk); if (tx_busy || !serial_out) seen = 1; end
        chk("rstmid_no_residue", seen, 0);
        #1;

        // backpressure: valid held high, count up on every accepted byte
        last_done = -1; pairs = 0; pb = 0; saw_full = 0;
        data_in = 8'h80;
        for (int i = 0; i < 700; i++) begin
            data_valid = 1'b1;
            acc = data_ready;
            if (fifo_level == DEPTH && !data_ready) saw_full = 1;
            if (pkt_done) last_done = tcyc;
            if (tx_busy && !pb && last_done >= 0) begin
                chk("bp_restart_gap", tcyc - last_done, 2);
                pairs++;
            end
            pb = tx_busy;
            @(negedge clk); #1;
            if (acc) data_in = data_in + 8'd1;
        end
        data_valid = 1'b0;
        chk("bp_saw_full", saw_full, 1);
        chk("bp_restart_seen", pairs > 0, 1);

        // randomized traffic
        dens = 1;
        for (int i = 0; i < 12000; i++) begin
            if (i % 2000 == 0) dens = $urandom_range(0, 12);
            data_valid = ($urandom_range(0, dens) == 0);
            data_in    = 8'($urandom);
            flush      = ($urandom_range(0, 150) == 0);
            @(negedge clk); #1;
        end
        data_valid = 1'b0;
        flush = 1'b0;

        // drain what is left
        pulse_flush();
        t = 0;
        while (!(tx_busy == 0 && fifo_level == 0 && wave.size() == 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        chk("drain", t < 3000, 1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
